// File: rtl/pkt_proc_deq_reader.sv
// Read-side companion of the packet processor: dequeues buffered words, checks
// sop/eop framing, measures packet length and forwards words through a credit-limited FWFT FIFO.
module pkt_proc_deq_reader #(
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 12,
    parameter int OFIFO_DEPTH = 4,
    parameter int RD_LAT      = 1,
    parameter int CNT_W       = 16
) (
    input  logic              pck_proc_int_mem_fsm_clk,
    input  logic              pck_proc_int_mem_fsm_rstn,
    input  logic              pck_proc_int_mem_fsm_sw_rstn,
    input  logic              rd_enable,
    input  logic              pck_proc_empty,
    output logic              deq_req,
    input  logic              out_sop,
    input  logic [DATA_W-1:0] rd_data_o,
    input  logic              out_eop,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sop,
    output logic              m_eop,
    output logic [LEN_W-1:0]  m_len,
    output logic              frame_err,
    output logic [CNT_W-1:0]  pkt_cnt
);

    localparam int PW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
    localparam int OW = $clog2(RD_LAT + 1);
    localparam int SW = PW + OW + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    logic clk;
    logic rst_n;
    logic clr_n;

    assign clk   = pck_proc_int_mem_fsm_clk;
    assign rst_n = pck_proc_int_mem_fsm_rstn;
    assign clr_n = pck_proc_int_mem_fsm_sw_rstn;

    state_e state_q, state_d;
    logic   fin_eop_q, fin_eop_d;

    logic [RD_LAT-1:0] strb_q, strb_d;
    logic [RD_LAT:0]   strb_pipe;
    logic              strobe;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     pending;
    logic              eop_cap;

    logic             in_pkt_q, in_pkt_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, cnt_nx;
    logic             frame_err_q, err_d;
    logic             push, push_sop, push_eop;
    logic [LEN_W-1:0] push_len;

    logic [DATA_W-1:0] data_mem [OFIFO_DEPTH];
    logic              sop_mem  [OFIFO_DEPTH];
    logic              eop_mem  [OFIFO_DEPTH];
    logic [LEN_W-1:0]  len_mem  [OFIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       fifo_cnt_q;
    logic              pop;
    logic [SW-1:0]     credit;

    logic [CNT_W-1:0]  pkt_cnt_q;

    // Each deq_req travels down this pipe; the tail marks the cycle its word is returned.
    assign strb_pipe = {strb_q, deq_req};
    assign strb_d    = strb_pipe[RD_LAT-1:0];
    assign strobe    = strb_q[RD_LAT-1];
    assign eop_cap   = strobe & out_eop;

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            outstanding = outstanding + OW'(strb_q[i]);
        end
    end

    assign pending = outstanding - OW'(strobe);
    assign credit  = SW'(fifo_cnt_q) + SW'(outstanding);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_q <= '0;
        end else if (!clr_n) begin
            strb_q <= '0;
        end else begin
            strb_q <= strb_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            fin_eop_q <= 1'b0;
        end else if (!clr_n) begin
            state_q   <= IDLE;
            fin_eop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fin_eop_q <= fin_eop_d;
        end
    end

    // Leaving RUN mid-packet drains to the eop in FINISH; fin_eop remembers that eop arrived.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rd_enable) state_d = RUN;
            end
            RUN: begin
                if (!rd_enable) begin
                    if (in_pkt_d) state_d = FINISH;
                    else if (outstanding == '0) state_d = IDLE;
                end
            end
            FINISH: begin
                if (rd_enable) state_d = RUN;
                else if ((fin_eop_q || eop_cap) && pending == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        fin_eop_d = (state_d == FINISH) && (fin_eop_q || (state_q == FINISH && eop_cap));
    end

    always_comb begin
        deq_req = 1'b0;
        if (clr_n && state_q != IDLE && !pck_proc_empty && credit < SW'(OFIFO_DEPTH)) begin
            deq_req = !(state_q == FINISH && (fin_eop_q || eop_cap));
        end
    end

    // Framing decode of the returned word: a sop inside a packet restarts it, a stray body word is dropped.
    always_comb begin
        push     = 1'b0;
        push_sop = 1'b0;
        push_eop = 1'b0;
        push_len = '0;
        err_d    = 1'b0;
        in_pkt_d = in_pkt_q;
        cnt_d    = cnt_q;
        cnt_nx   = cnt_q;
        if (strobe) begin
            if (out_sop) begin
                err_d    = in_pkt_q;
                push     = 1'b1;
                push_sop = 1'b1;
                cnt_nx   = LEN_W'(1);
            end else if (in_pkt_q) begin
                push   = 1'b1;
                cnt_nx = (cnt_q == LEN_MAX) ? cnt_q : cnt_q + LEN_W'(1);
            end else begin
                err_d = 1'b1;
            end
            if (push) begin
                cnt_d = cnt_nx;
                if (out_eop) begin
                    push_eop = 1'b1;
                    push_len = cnt_nx;
                    in_pkt_d = 1'b0;
                end else begin
                    in_pkt_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_pkt_q    <= 1'b0;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
        end else if (!clr_n) begin
            in_pkt_q    <= 1'b0;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            in_pkt_q    <= in_pkt_d;
            cnt_q       <= cnt_d;
            frame_err_q <= err_d;
        end
    end

    assign pop = m_valid & m_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= rd_data_o;
            sop_mem[wr_ptr_q]  <= push_sop;
            eop_mem[wr_ptr_q]  <= push_eop;
            len_mem[wr_ptr_q]  <= push_len;
        end
    end

    // The credit check on deq_req guarantees a push never lands on a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else if (!clr_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + (PW+1)'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - (PW+1)'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q <= '0;
        end else if (!clr_n) begin
            pkt_cnt_q <= '0;
        end else if (pop && m_eop) begin
            pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
        end
    end

    assign m_valid   = (fifo_cnt_q != '0);
    assign m_data    = m_valid ? data_mem[rd_ptr_q] : '0;
    assign m_sop     = m_valid ? sop_mem[rd_ptr_q]  : 1'b0;
    assign m_eop     = m_valid ? eop_mem[rd_ptr_q]  : 1'b0;
    assign m_len     = m_valid ? len_mem[rd_ptr_q]  : '0;
    assign frame_err = frame_err_q;
    assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_pkt_proc_deq_reader.sv
// Directed bench for pkt_proc_deq_reader with a reactive RD_LAT=1 processor model
// and a downstream monitor that records every accepted word.
module tb_pkt_proc_deq_reader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        swRstn = 1'b1;
    logic        rdEnable = 1'b0;
    logic        procEmpty;
    logic        deqReq;
    logic        outSop = 1'b0;
    logic [31:0] rdData = 32'd0;
    logic        outEop = 1'b0;
    logic        mValid;
    logic        mReady = 1'b0;
    logic [31:0] mData;
    logic        mSop;
    logic        mEop;
    logic [11:0] mLen;
    logic        frameErr;
    logic [15:0] pktCnt;

    logic [33:0] procMem [0:63];
    int          procWr = 0;
    int          procRd = 0;
    logic        reqPend = 1'b0;
    int          reqCount = 0;
    int          feCount = 0;
    int          rxCnt = 0;
    logic [45:0] rxMem [0:127];

    int vectors = 0;
    int miscompares = 0;

    pkt_proc_deq_reader dut (
        .pck_proc_int_mem_fsm_clk     (clk),
        .pck_proc_int_mem_fsm_rstn    (rstn),
        .pck_proc_int_mem_fsm_sw_rstn (swRstn),
        .rd_enable                    (rdEnable),
        .pck_proc_empty               (procEmpty),
        .deq_req                      (deqReq),
        .out_sop                      (outSop),
        .rd_data_o                    (rdData),
        .out_eop                      (outEop),
        .m_valid                      (mValid),
        .m_ready                      (mReady),
        .m_data                       (mData),
        .m_sop                        (mSop),
        .m_eop                        (mEop),
        .m_len                        (mLen),
        .frame_err                    (frameErr),
        .pkt_cnt                      (pktCnt)
    );

    always #5 clk = ~clk;

    assign procEmpty = (procRd == procWr);

    // Mid-cycle observer: requests, frame errors and words accepted downstream.
    always @(negedge clk) begin
        reqPend = deqReq;
        if (deqReq) reqCount++;
        if (frameErr) feCount++;
        if (mValid && mReady) begin
            rxMem[rxCnt] = {mSop, mEop, mLen, mData};
            rxCnt++;
        end
    end

    // Processor model: a request seen in one cycle returns its word in the next; junk otherwise.
    always @(posedge clk) begin
        #1;
        if (reqPend && procRd < procWr) begin
            {outSop, outEop, rdData} = procMem[procRd];
            procRd++;
        end else begin
            outSop = 1'b1;
            outEop = 1'b1;
            rdData = 32'hBAD0_0BAD;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [45:0] mkWord(input logic s, input logic e,
                                           input logic [11:0] l, input logic [31:0] d);
        return {s, e, l, d};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushWord(input logic s, input logic e, input logic [31:0] d);
        procMem[procWr] = {s, e, d};
        procWr++;
    endtask

    task automatic loadPacket(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) pushWord(i == 0, i == n - 1, base + 32'(i));
    endtask

    task automatic waitRx(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            if (rxCnt >= target) ok = 1'b1;
            else tick(1);
        end
        if (rxCnt >= target) ok = 1'b1;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        tick(3);
        vectors++;
        if ({deqReq, mValid, mSop, mEop, frameErr} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {deqReq, mValid, mSop, mEop, frameErr});
        end
        vectors++;
        if (mData !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_m_data: got %h expected 0", mData);
        end
        vectors++;
        if (mLen !== 12'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_m_len: got %0d expected 0", mLen);
        end
        vectors++;
        if (pktCnt !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_pkt_cnt: got %0d expected 0", pktCnt);
        end
        rstn = 1'b1;
        tick(2);
    endtask

    task automatic test_single_packet;
        int r0, q0, f0;
        bit ok;
        logic [45:0] expW;
        r0 = rxCnt; q0 = reqCount; f0 = feCount;
        loadPacket(4, 32'h1000_0000);
        mReady = 1'b1;
        rdEnable = 1'b1;
        waitRx(r0 + 4, 60, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL single_timeout: got %0d words expected 4", rxCnt - r0);
        end
        rdEnable = 1'b0;
        tick(4);
        vectors++;
        if (reqCount - q0 != 4) begin
            miscompares++;
            $display("[TB] FAIL single_deq_count: got %0d expected 4", reqCount - q0);
        end
        for (int i = 0; i < 4; i++) begin
            expW = mkWord(i == 0, i == 3, (i == 3) ? 12'd4 : 12'd0, 32'h1000_0000 + 32'(i));
            vectors++;
            if (rxMem[r0 + i] !== expW) begin
                miscompares++;
                $display("[TB] FAIL single_word%0d: got %h expected %h", i, rxMem[r0 + i], expW);
            end
        end
        vectors++;
        if (pktCnt !== 16'd1 || feCount != f0) begin
            miscompares++;
            $display("[TB] FAIL single_cnt_err: got pkt_cnt=%0d ferr=%0d expected 1 and 0", pktCnt, feCount - f0);
        end
    endtask

    task automatic test_backpressure;
        int r0, q0;
        bit ok;
        logic [45:0] expW;
        r0 = rxCnt; q0 = reqCount;
        mReady = 1'b0;
        loadPacket(10, 32'h2000_0000);
        rdEnable = 1'b1;
        tick(20);
        vectors++;
        if (reqCount - q0 != 4) begin
            miscompares++;
            $display("[TB] FAIL bp_credit_stop: got %0d requests expected 4", reqCount - q0);
        end
        vectors++;
        if ({mValid, mSop, mEop, mData} !== {3'b110, 32'h2000_0000} || rxCnt != r0) begin
            miscompares++;
            $display("[TB] FAIL bp_hold: got v/s/e=%b%b%b data=%h expected 110 data=20000000",
                     mValid, mSop, mEop, mData);
        end
        mReady = 1'b1;
        waitRx(r0 + 10, 80, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL bp_timeout: got %0d words expected 10", rxCnt - r0);
        end
        rdEnable = 1'b0;
        tick(4);
        for (int i = 0; i < 10; i++) begin
            expW = mkWord(i == 0, i == 9, (i == 9) ? 12'd10 : 12'd0, 32'h2000_0000 + 32'(i));
            vectors++;
            if (rxMem[r0 + i] !== expW) begin
                miscompares++;
                $display("[TB] FAIL bp_word%0d: got %h expected %h", i, rxMem[r0 + i], expW);
            end
        end
        vectors++;
        if (reqCount - q0 != 10 || pktCnt !== 16'd2) begin
            miscompares++;
            $display("[TB] FAIL bp_totals: got req=%0d pkt_cnt=%0d expected 10 and 2", reqCount - q0, pktCnt);
        end
    endtask

    task automatic test_double_sop;
        int r0, f0;
        bit ok;
        logic [45:0] expW [5];
        r0 = rxCnt; f0 = feCount;
        expW[0] = mkWord(1'b1, 1'b0, 12'd0, 32'h3000_0000);
        expW[1] = mkWord(1'b0, 1'b0, 12'd0, 32'h3000_0001);
        expW[2] = mkWord(1'b1, 1'b0, 12'd0, 32'h3000_0002);
        expW[3] = mkWord(1'b0, 1'b0, 12'd0, 32'h3000_0003);
        expW[4] = mkWord(1'b0, 1'b1, 12'd3, 32'h3000_0004);
        pushWord(1'b1, 1'b0, 32'h3000_0000);
        pushWord(1'b0, 1'b0, 32'h3000_0001);
        pushWord(1'b1, 1'b0, 32'h3000_0002);
        pushWord(1'b0, 1'b0, 32'h3000_0003);
        pushWord(1'b0, 1'b1, 32'h3000_0004);
        mReady = 1'b1;
        rdEnable = 1'b1;
        waitRx(r0 + 5, 60, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL dsop_timeout: got %0d words expected 5", rxCnt - r0);
        end
        rdEnable = 1'b0;
        tick(4);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (rxMem[r0 + i] !== expW[i]) begin
                miscompares++;
                $display("[TB] FAIL dsop_word%0d: got %h expected %h", i, rxMem[r0 + i], expW[i]);
            end
        end
        vectors++;
        if (feCount - f0 != 1 || pktCnt !== 16'd3) begin
            miscompares++;
            $display("[TB] FAIL dsop_err_cnt: got ferr=%0d pkt_cnt=%0d expected 1 and 3", feCount - f0, pktCnt);
        end
    endtask

    task automatic test_orphan_word;
        int r0, f0;
        bit ok;
        rstn = 1'b0;
        tick(2);
        vectors++;
        if (pktCnt !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL orphan_reset_cnt: got %0d expected 0", pktCnt);
        end
        rstn = 1'b1;
        tick(1);
        r0 = rxCnt; f0 = feCount;
        pushWord(1'b0, 1'b0, 32'h4000_0000);
        pushWord(1'b1, 1'b1, 32'h4000_0001);
        mReady = 1'b1;
        rdEnable = 1'b1;
        waitRx(r0 + 1, 40, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL orphan_timeout: got %0d words expected 1", rxCnt - r0);
        end
        rdEnable = 1'b0;
        tick(5);
        vectors++;
        if (rxMem[r0] !== mkWord(1'b1, 1'b1, 12'd1, 32'h4000_0001) || rxCnt - r0 != 1) begin
            miscompares++;
            $display("[TB] FAIL orphan_single: got %h (%0d words) expected %h (1 word)",
                     rxMem[r0], rxCnt - r0, mkWord(1'b1, 1'b1, 12'd1, 32'h4000_0001));
        end
        vectors++;
        if (feCount - f0 != 1 || pktCnt !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL orphan_err_cnt: got ferr=%0d pkt_cnt=%0d expected 1 and 1", feCount - f0, pktCnt);
        end
    endtask

    task automatic test_finish_drain;
        int r0, q0, f0;
        bit ok;
        logic [45:0] expW;
        r0 = rxCnt; q0 = reqCount; f0 = feCount;
        loadPacket(6, 32'h5000_0000);
        loadPacket(6, 32'h6000_0000);
        mReady = 1'b1;
        rdEnable = 1'b1;
        for (int c = 0; c < 30 && reqCount - q0 < 2; c++) tick(1);
        rdEnable = 1'b0;
        waitRx(r0 + 6, 60, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL finish_timeout: got %0d words expected 6", rxCnt - r0);
        end
        tick(20);
        vectors++;
        if (reqCount - q0 != 6 || deqReq !== 1'b0 || procEmpty !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL finish_stop: got req=%0d deq_req=%b expected 6 and 0 with data pending",
                     reqCount - q0, deqReq);
        end
        for (int i = 0; i < 6; i++) begin
            expW = mkWord(i == 0, i == 5, (i == 5) ? 12'd6 : 12'd0, 32'h5000_0000 + 32'(i));
            vectors++;
            if (rxMem[r0 + i] !== expW) begin
                miscompares++;
                $display("[TB] FAIL finish_word%0d: got %h expected %h", i, rxMem[r0 + i], expW);
            end
        end
        vectors++;
        if (rxCnt - r0 != 6 || feCount != f0 || pktCnt !== 16'd2) begin
            miscompares++;
            $display("[TB] FAIL finish_totals: got words=%0d ferr=%0d pkt_cnt=%0d expected 6, 0, 2",
                     rxCnt - r0, feCount - f0, pktCnt);
        end
    endtask

    task automatic test_async_reset;
        int r0, q0, f0;
        r0 = rxCnt; q0 = reqCount; f0 = feCount;
        mReady = 1'b0;
        rdEnable = 1'b1;
        for (int c = 0; c < 40 && reqCount - q0 < 4; c++) @(posedge clk);
        #2;
        vectors++;
        if (mValid !== 1'b1 || pktCnt !== 16'd2 || reqCount - q0 != 4) begin
            miscompares++;
            $display("[TB] FAIL areset_pre: got valid=%b pkt_cnt=%0d req=%0d expected 1, 2, 4",
                     mValid, pktCnt, reqCount - q0);
        end
        rstn = 1'b0;
        rdEnable = 1'b0;
        #1;
        vectors++;
        if ({deqReq, mValid, mSop, mEop, frameErr} !== 5'b0 || mData !== 32'd0 || mLen !== 12'd0) begin
            miscompares++;
            $display("[TB] FAIL areset_outputs: got flags=%b data=%h len=%0d expected all 0",
                     {deqReq, mValid, mSop, mEop, frameErr}, mData, mLen);
        end
        vectors++;
        if (pktCnt !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL areset_pkt_cnt: got %0d expected 0", pktCnt);
        end
        mReady = 1'b1;
        tick(3);
        rstn = 1'b1;
        tick(5);
        vectors++;
        if (mValid !== 1'b0 || rxCnt != r0 || reqCount - q0 != 4) begin
            miscompares++;
            $display("[TB] FAIL areset_discard: got valid=%b words=%0d req=%0d expected 0, 0, 4",
                     mValid, rxCnt - r0, reqCount - q0);
        end
        rdEnable = 1'b1;
        tick(10);
        rdEnable = 1'b0;
        tick(5);
        vectors++;
        if (feCount - f0 != 2 || rxCnt != r0 || pktCnt !== 16'd0 || reqCount - q0 != 6) begin
            miscompares++;
            $display("[TB] FAIL areset_orphans: got ferr=%0d words=%0d pkt_cnt=%0d req=%0d expected 2, 0, 0, 6",
                     feCount - f0, rxCnt - r0, pktCnt, reqCount - q0);
        end
    endtask

    initial begin
        $display("[TB] starting pkt_proc_deq_reader bench");
        test_reset();
        test_single_packet();
        test_backpressure();
        test_double_sop();
        test_orphan_word();
        test_finish_drain();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pkt_proc_deq_reader.md
Name: pkt_proc_deq_reader

Overview:
- Read-side companion of the packet processor. It consumes packets that the packet processor has already buffered.
- Issues deq_req against the processor's read port and captures out_sop / rd_data_o / out_eop.
- Checks framing, measures packet length, and forwards words to a downstream valid/ready sink through a small credit-controlled output FIFO.
- Sits between the packet processor dequeue port and the egress logic. It is also reused as the reactive read agent's reference model.

Parameters:
- DATA_W, 32, width of rd_data_o and m_data
- LEN_W, 12, width of the per-packet word counter and m_len
- OFIFO_DEPTH, 4, output FIFO depth in words (power of 2, minimum 2)
- RD_LAT, 1, cycles from deq_req high to the matching out_sop/rd_data_o/out_eop sample (1 or 2)
- CNT_W, 16, width of pkt_cnt

Ports:
- pck_proc_int_mem_fsm_clk  in  1  clock; all logic on posedge
- pck_proc_int_mem_fsm_rstn  in  1  asynchronous active-low reset
- pck_proc_int_mem_fsm_sw_rstn  in  1  synchronous active-low clear; same effect as reset
- rd_enable  in  1  start/continue reading; deassertion takes effect at the next packet boundary
- pck_proc_empty  in  1  processor empty flag
- deq_req  out  1  dequeue request to the processor, one word per cycle high
- out_sop  in  1  start of packet, sampled with the returned word
- rd_data_o  in  DATA_W  returned word
- out_eop  in  1  end of packet, sampled with the returned word
- m_valid  out  1  downstream word valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_W  downstream word
- m_sop  out  1  first word of packet
- m_eop  out  1  last word of packet
- m_len  out  LEN_W  packet length in words; valid when m_eop=1, otherwise 0
- frame_err  out  1  one-cycle pulse on a framing violation
- pkt_cnt  out  CNT_W  count of packets completed downstream; wraps

Behaviour:
- Reset/sw_rstn:
  - deq_req=0, m_valid=0, m_data=0, m_sop=0, m_eop=0, m_len=0, frame_err=0, pkt_cnt=0.
  - FIFO emptied, outstanding-read pipeline cleared, in_pkt=0, word counter=0, state=IDLE.
  - Read returns still in flight are discarded.
- Read return strobe: deq_req delayed RD_LAT cycles through a shift register. A word is captured only when the strobe=1; out_sop/out_eop are ignored otherwise.
- Credit rule: deq_req = state!=IDLE & !pck_proc_empty & (fifo_count + outstanding) < OFIFO_DEPTH.
  - outstanding = number of 1s in the strobe pipeline.
  - The FIFO therefore never overflows.
- FSM:
  - IDLE -> RUN when rd_enable=1.
  - RUN -> FINISH when rd_enable=0 and in_pkt=1.
  - RUN -> IDLE when rd_enable=0 and in_pkt=0 and outstanding=0.
  - FINISH -> IDLE the cycle after a captured word with out_eop=1 and outstanding=0.
  - In FINISH, deq_req stops being issued once an eop word has been captured.
  - rd_enable reasserting in FINISH returns the FSM to RUN.
- Framing, evaluated on each captured word:
  - sop=1, in_pkt=0: start a packet; counter=1; word pushed with sop tag.
  - sop=0, in_pkt=1: counter+1, saturating at 2^LEN_W-1; word pushed.
  - sop=1, in_pkt=1: frame_err pulse. The previous packet is closed by pushing this word as a new sop; the previous packet gets no eop. Counter restarts at 1.
  - sop=0, in_pkt=0: frame_err pulse; word dropped, not pushed.
  - eop=1: word pushed with eop tag and the counter value in len; in_pkt=0.
  - sop=1 and eop=1 together: a single-word packet, len=1.
- Output: first-word-fall-through FIFO of {data, sop, eop, len}. m_valid = !fifo_empty.
  - Pop on m_valid & m_ready.
  - m_data/m_sop/m_eop/m_len hold stable while m_valid & !m_ready.
- pkt_cnt increments on each pop with m_eop=1; it wraps at 2^CNT_W.
- Simultaneous push and pop keep the FIFO count unchanged.
- pck_proc_empty rising while reads are outstanding: the outstanding returns are still captured.
- Async reset mid-packet: all state is cleared immediately. After release, the first non-sop word raises frame_err and is dropped.

Test Plan:
- 1. Single 4-word packet, m_ready=1, RD_LAT=1 -> deq_req high for 4 cycles. m_sop on word0, m_eop on word3 with m_len=4; pkt_cnt=1; frame_err never asserts.
- 2. m_ready=0 during a 10-word packet -> deq_req stops after 4 outstanding+buffered words with no loss. After m_ready=1, all 10 words are delivered in order with m_len=10.
- 3. Return sequence sop,data,sop,data,eop -> frame_err pulses once at the second sop. Downstream sees sop,data,sop,data,eop with the final m_len=3, and pkt_cnt=1.
- 4. Word without sop after reset -> frame_err pulses and the word is dropped. A following sop/eop single word gives m_len=1 and m_sop=m_eop=1.
- 5. rd_enable deasserted after word 2 of a 6-word packet -> FSM enters FINISH. The remaining 4 words are read, deq_req is then 0, state=IDLE, and no further reads occur even though empty=0.
- 6. Assert rstn low mid-packet with 3 words buffered and 1 outstanding -> all outputs return to 0 asynchronously. The late return is discarded and pkt_cnt=0.
